dpsk_tx_frame_mod: RTL

DPSK_TX_FRAME_MOD -- requirements
Module: dpsk_tx_frame_mod

---
 rtl/dpsk_pkg.sv | 29 ++
 rtl/dpsk_byte_fifo.sv | 62 ++++++
 rtl/dpsk_tx_frame_mod.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dpsk_pkg.sv
// Shared types and helpers for the DPSK framed transmitter.
package dpsk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SYNC     = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    typedef enum logic {
        MODE_DBPSK = 1'b0,
        MODE_DQPSK = 1'b1
    } mode_e;

    // DQPSK dibit to phase step, expressed in quarter turns (Gray mapping)
    function automatic logic [1:0] dqpsk_quarters(input logic [1:0] dibit);
        logic [1:0] q;
        case (dibit)
            2'b00:   q = 2'd0;
            2'b01:   q = 2'd1;
            2'b11:   q = 2'd2;
            default: q = 2'd3;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/dpsk_byte_fifo.sv
// Synchronous show-ahead byte FIFO with occupancy count and registered ready.
module dpsk_byte_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_c,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_n;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && ready;
    assign do_pop  = pop && (count != '0);
    assign head_c  = mem[rd_ptr];

    // Occupancy update; simultaneous push and pop leave it unchanged
    always_comb begin
        count_n = count;
        case ({do_push, do_pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    // Storage array (no reset needed, guarded by count)
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, count and ready flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_n;
            ready <= (count_n < CW'(DEPTH));
        end
    end

endmodule

// File: rtl/dpsk_tx_frame_mod.sv
// Framed differential PSK transmitter: preamble, sync and payload bytes are
// serialised MSB first into DBPSK/DQPSK symbols riding on an NCO carrier.
module dpsk_tx_frame_mod
    import dpsk_pkg::*;
#(
    parameter int unsigned          DATA_W        = 8,
    parameter int unsigned          FIFO_DEPTH    = 16,
    parameter int unsigned          PREAMBLE_LEN  = 2,
    parameter logic [DATA_W-1:0]    PREAMBLE_BYTE = DATA_W'(8'hAA),
    parameter logic [DATA_W-1:0]    SYNC_BYTE     = DATA_W'(8'h7E),
    parameter int unsigned          SPS           = 16,
    parameter int unsigned          PHASE_W       = 10,
    parameter int unsigned          FREQ_WORD     = 64
) (
    input  logic                            sys_clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [DATA_W-1:0]               in_data,
    output logic                            in_ready,
    input  logic                            mode,
    input  logic [$clog2(FIFO_DEPTH+1)-1:0] frame_len,
    output logic [PHASE_W-1:0]              out_phase,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            frame_done
);

    localparam int unsigned LEN_W = $clog2(FIFO_DEPTH+1);
    localparam int unsigned SW    = $clog2(SPS);
    localparam int unsigned SCW   = $clog2(DATA_W);
    localparam int unsigned PCW   = $clog2(PREAMBLE_LEN+1);

    state_e              state;
    state_e              state_next;
    mode_e               mode_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    eff_len;
    logic [LEN_W-1:0]    pay_cnt;
    logic [PCW-1:0]      pre_cnt;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   shreg_n;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   next_byte;
    logic [SCW-1:0]      sym_cnt;
    logic [SCW-1:0]      last_sym;
    logic [SW-1:0]       samp_cnt;
    logic [PHASE_W-1:0]  nco_acc;
    logic [PHASE_W-1:0]  nco_n;
    logic [PHASE_W-1:0]  sym_phase;
    logic [PHASE_W-1:0]  sym_n;

    logic                start_ok;
    logic                start;
    logic                load_pre;
    logic                load_sync;
    logic                load_pay;
    logic                frame_end;
    logic                accept;
    logic                sym_end;
    logic                byte_end;

    logic [LEN_W-1:0]    fifo_count;
    logic [DATA_W-1:0]   fifo_head;

    // Phase step of the symbol at the top of a byte
    function automatic logic [PHASE_W-1:0] first_step(input logic [DATA_W-1:0] b,
                                                      input mode_e m);
        logic [1:0] q;
        if (m == MODE_DQPSK) q = dqpsk_quarters(b[DATA_W-1 -: 2]);
        else                 q = b[DATA_W-1] ? 2'd2 : 2'd0;
        return PHASE_W'(q) << (PHASE_W-2);
    endfunction

    dpsk_byte_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (load_pay),
        .head_c    (fifo_head),
        .count     (fifo_count),
        .ready     (in_ready)
    );

    // Frame length clamp, start qualifier and symbol/byte boundary strobes
    always_comb begin
        eff_len  = (frame_len > LEN_W'(FIFO_DEPTH)) ? LEN_W'(FIFO_DEPTH) : frame_len;
        start_ok = (eff_len != '0) && (fifo_count >= eff_len);
        accept   = out_valid && out_ready;
        sym_end  = accept && (samp_cnt == SW'(SPS-1));
        last_sym = (mode_q == MODE_DQPSK) ? SCW'(DATA_W/2-1) : SCW'(DATA_W-1);
        byte_end = sym_end && (sym_cnt == last_sym);
    end

    // FSM state register
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (start_ok) state_next = ST_PREAMBLE;
            ST_PREAMBLE: if (byte_end && (pre_cnt == PCW'(PREAMBLE_LEN))) state_next = ST_SYNC;
            ST_SYNC:     if (byte_end) state_next = ST_PAYLOAD;
            ST_PAYLOAD:  if (byte_end && (pay_cnt == len_q)) state_next = ST_DONE;
            ST_DONE:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // FSM control outputs: which byte to load next, or end of frame
    always_comb begin
        start     = 1'b0;
        load_pre  = 1'b0;
        load_sync = 1'b0;
        load_pay  = 1'b0;
        frame_end = 1'b0;
        case (state)
            ST_IDLE: start = start_ok;
            ST_PREAMBLE: begin
                if (byte_end) begin
                    if (pre_cnt == PCW'(PREAMBLE_LEN)) load_sync = 1'b1;
                    else                               load_pre  = 1'b1;
                end
            end
            ST_SYNC: load_pay = byte_end;
            ST_PAYLOAD: begin
                if (byte_end) begin
                    if (pay_cnt == len_q) frame_end = 1'b1;
                    else                  load_pay  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Next shift register, carrier and symbol phase
    always_comb begin
        shreg_n   = shreg;
        nco_n     = nco_acc;
        sym_n     = sym_phase;
        next_byte = PREAMBLE_BYTE;
        if (load_sync) next_byte = SYNC_BYTE;
        if (load_pay)  next_byte = fifo_head;
        shifted = (mode_q == MODE_DQPSK) ? (shreg << 2) : (shreg << 1);
        if (start) begin
            shreg_n = PREAMBLE_BYTE;
            nco_n   = '0;
            sym_n   = first_step(PREAMBLE_BYTE, mode_e'(mode));
        end else if (accept) begin
            nco_n = nco_acc + PHASE_W'(FREQ_WORD);
            if (sym_end && !frame_end) begin
                shreg_n = byte_end ? next_byte : shifted;
                sym_n   = sym_phase + first_step(shreg_n, mode_q);
            end
        end
    end

    // Datapath registers and registered status outputs
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_DBPSK;
            len_q      <= '0;
            shreg      <= '0;
            sym_cnt    <= '0;
            samp_cnt   <= '0;
            pre_cnt    <= '0;
            pay_cnt    <= '0;
            nco_acc    <= '0;
            sym_phase  <= '0;
            out_phase  <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            shreg      <= shreg_n;
            nco_acc    <= nco_n;
            sym_phase  <= sym_n;
            out_phase  <= nco_n + sym_n;
            busy       <= (state_next != ST_IDLE);
            frame_done <= (state_next == ST_DONE);
            if (start) begin
                mode_q    <= mode_e'(mode);
                len_q     <= eff_len;
                sym_cnt   <= '0;
                samp_cnt  <= '0;
                pre_cnt   <= PCW'(1);
                pay_cnt   <= '0;
                out_valid <= 1'b1;
            end else if (accept) begin
                samp_cnt <= sym_end ? '0 : samp_cnt + SW'(1);
                if (sym_end)   sym_cnt   <= byte_end ? '0 : sym_cnt + SCW'(1);
                if (load_pre)  pre_cnt   <= pre_cnt + PCW'(1);
                if (load_pay)  pay_cnt   <= pay_cnt + LEN_W'(1);
                if (frame_end) out_valid <= 1'b0;
            end
        end
    end

endmodule
